axis_pkt_src: RTL and testbench



---
 rtl/axis_pkt_src_if.sv | 36 +++
 rtl/axis_pkt_src.sv | 257 +++++++++++++++++++++++++
 tb/tb_axis_pkt_src.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pkt_src_if.sv
// Egress bundle of axis_pkt_src: 256b DAT channel plus LEN/SPT/DPT/ERR sideband channels.
interface axis_pkt_src_if #(
  parameter int unsigned DW = 256
);
  logic [DW-1:0]   dat_tdata;
  logic [DW/8-1:0] dat_tstrb;
  logic            dat_tlast;
  logic            dat_tvalid;
  logic            dat_tready;
  logic [15:0]     len_tdata;
  logic            len_tvalid;
  logic            len_tready;
  logic [7:0]      spt_tdata;
  logic            spt_tvalid;
  logic            spt_tready;
  logic [7:0]      dpt_tdata;
  logic            dpt_tvalid;
  logic            dpt_tready;
  logic [7:0]      err_tdata;
  logic            err_tvalid;
  logic            err_tready;

  modport master (
    output dat_tdata, dat_tstrb, dat_tlast, dat_tvalid,
    output len_tdata, len_tvalid, spt_tdata, spt_tvalid,
    output dpt_tdata, dpt_tvalid, err_tdata, err_tvalid,
    input  dat_tready, len_tready, spt_tready, dpt_tready, err_tready
  );

  modport slave (
    input  dat_tdata, dat_tstrb, dat_tlast, dat_tvalid,
    input  len_tdata, len_tvalid, spt_tdata, spt_tvalid,
    input  dpt_tdata, dpt_tvalid, err_tdata, err_tvalid,
    output dat_tready, len_tready, spt_tready, dpt_tready, err_tready
  );
endinterface

// File: rtl/axis_pkt_src.sv
// AXI4-Stream packet source: one sideband beat per channel, then deterministic DAT payload.
// Optional error tagging on the ERR channel is enabled by defining PKTGEN_ERR_INJECT_EN.
module axis_pkt_src #(
  parameter int unsigned DW = 256
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] pkt_len,
  input  logic [15:0] num_pkts,
  input  logic [7:0]  spt,
  input  logic [7:0]  dpt,
`ifdef PKTGEN_ERR_INJECT_EN
  input  logic [7:0]  err_every,
`endif
  output logic        busy,
  output logic        done,
  output logic        start_err,
  output logic [31:0] pkt_cnt,
  axis_pkt_src_if.master m_axis
);

  localparam int unsigned Lanes = DW / 32;
  localparam int unsigned Bytes = DW / 8;

  typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

  state_e          state_q, state_d;
  logic [15:0]     len_q, len_d, num_q, num_d;
  logic [7:0]      spt_q, spt_d, dpt_q, dpt_d, err_q, err_d;
  logic [15:0]     pkt_idx_q, pkt_idx_d, beat_q, beat_d, last_beat_q, last_beat_d;
  logic            stop_q, stop_d, busy_q, busy_d, done_q, done_d, start_err_q, start_err_d;
  logic [31:0]     pkt_cnt_q, pkt_cnt_d;
  logic            len_v_q, len_v_d, spt_v_q, spt_v_d, dpt_v_q, dpt_v_d, err_v_q, err_v_d;
  logic            dat_v_q, dat_v_d, dat_last_q, dat_last_d;
  logic [DW-1:0]   dat_data_q, dat_data_d;
  logic [Bytes-1:0] dat_strb_q, dat_strb_d;
`ifdef PKTGEN_ERR_INJECT_EN
  logic [7:0]      err_every_q, err_every_d, err_ctr_q, err_ctr_d;
  logic [8:0]      err_ctr_inc;
`endif

  logic [16:0]      nb;
  logic [15:0]      nxt_beat;
  logic [DW-1:0]    nxt_data;
  logic [Bytes-1:0] nxt_strb;
  logic             nxt_last;
  logic             finish;

  // Payload of the beat that will be presented next: beat 0 from HDR, beat_q+1 from DATA.
  always_comb begin
    nb       = ({1'b0, pkt_len} + 17'd31) >> 5;
    nxt_beat = (state_q == StHdr) ? 16'd0 : beat_q + 16'd1;
    nxt_last = (nxt_beat == last_beat_q);
    nxt_data = '0;
    nxt_strb = '0;
    for (int i = 0; i < Lanes; i++) begin
      nxt_data[32*i +: 32] = {pkt_idx_q, (nxt_beat << 3) + 16'(i)};
    end
    for (int j = 0; j < Bytes; j++) begin
      nxt_strb[j] = !nxt_last || (len_q[4:0] == 5'd0) || (5'(j) < len_q[4:0]);
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    num_d       = num_q;
    spt_d       = spt_q;
    dpt_d       = dpt_q;
    err_d       = err_q;
    pkt_idx_d   = pkt_idx_q;
    beat_d      = beat_q;
    last_beat_d = last_beat_q;
    stop_d      = stop_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    start_err_d = 1'b0;
    pkt_cnt_d   = pkt_cnt_q;
    len_v_d     = len_v_q;
    spt_v_d     = spt_v_q;
    dpt_v_d     = dpt_v_q;
    err_v_d     = err_v_q;
    dat_v_d     = dat_v_q;
    dat_last_d  = dat_last_q;
    dat_data_d  = dat_data_q;
    dat_strb_d  = dat_strb_q;
    finish      = 1'b0;
`ifdef PKTGEN_ERR_INJECT_EN
    err_every_d = err_every_q;
    err_ctr_d   = err_ctr_q;
    err_ctr_inc = {1'b0, err_ctr_q} + 9'd1;
`endif

    case (state_q)
      StIdle: begin
        stop_d = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          if (pkt_len == 16'd0) begin
            start_err_d = 1'b1;
          end else begin
            state_d     = StHdr;
            len_d       = pkt_len;
            num_d       = num_pkts;
            spt_d       = spt;
            dpt_d       = dpt;
            pkt_idx_d   = 16'd0;
            beat_d      = 16'd0;
            last_beat_d = nb[15:0] - 16'd1;
            busy_d      = 1'b1;
            len_v_d     = 1'b1;
            spt_v_d     = 1'b1;
            dpt_v_d     = 1'b1;
            err_v_d     = 1'b1;
`ifdef PKTGEN_ERR_INJECT_EN
            // err_ctr tracks (pkt_idx+1) mod err_every for the packet in flight.
            err_every_d = err_every;
            err_ctr_d   = (err_every == 8'd1) ? 8'd0 : 8'd1;
            err_d       = (err_every == 8'd1) ? 8'h01 : 8'h00;
`else
            err_d       = 8'h00;
`endif
          end
        end
      end

      StHdr: begin
        stop_d = stop_q | stop;
        if (m_axis.len_tready) len_v_d = 1'b0;
        if (m_axis.spt_tready) spt_v_d = 1'b0;
        if (m_axis.dpt_tready) dpt_v_d = 1'b0;
        if (m_axis.err_tready) err_v_d = 1'b0;
        if (!len_v_d && !spt_v_d && !dpt_v_d && !err_v_d) begin
          state_d    = StData;
          beat_d     = nxt_beat;
          dat_v_d    = 1'b1;
          dat_data_d = nxt_data;
          dat_strb_d = nxt_strb;
          dat_last_d = nxt_last;
        end
      end

      StData: begin
        stop_d = stop_q | stop;
        if (m_axis.dat_tready) begin
          if (dat_last_q) begin
            pkt_cnt_d  = pkt_cnt_q + 32'd1;
            pkt_idx_d  = pkt_idx_q + 16'd1;
            dat_v_d    = 1'b0;
            dat_last_d = 1'b0;
            finish     = stop_q || stop || ((num_q != 16'd0) && (pkt_idx_d == num_q));
            if (finish) begin
              state_d = StIdle;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d = StHdr;
              len_v_d = 1'b1;
              spt_v_d = 1'b1;
              dpt_v_d = 1'b1;
              err_v_d = 1'b1;
`ifdef PKTGEN_ERR_INJECT_EN
              err_ctr_d = (err_ctr_inc == {1'b0, err_every_q}) ? 8'd0 : err_ctr_inc[7:0];
              err_d     = ((err_every_q != 8'd0) && (err_ctr_d == 8'd0)) ? 8'h01 : 8'h00;
`endif
            end
          end else begin
            beat_d     = nxt_beat;
            dat_data_d = nxt_data;
            dat_strb_d = nxt_strb;
            dat_last_d = nxt_last;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= StIdle;
      len_q       <= '0;
      num_q       <= '0;
      spt_q       <= '0;
      dpt_q       <= '0;
      err_q       <= '0;
      pkt_idx_q   <= '0;
      beat_q      <= '0;
      last_beat_q <= '0;
      stop_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
      pkt_cnt_q   <= '0;
      len_v_q     <= 1'b0;
      spt_v_q     <= 1'b0;
      dpt_v_q     <= 1'b0;
      err_v_q     <= 1'b0;
      dat_v_q     <= 1'b0;
      dat_last_q  <= 1'b0;
      dat_data_q  <= '0;
      dat_strb_q  <= '0;
`ifdef PKTGEN_ERR_INJECT_EN
      err_every_q <= '0;
      err_ctr_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      num_q       <= num_d;
      spt_q       <= spt_d;
      dpt_q       <= dpt_d;
      err_q       <= err_d;
      pkt_idx_q   <= pkt_idx_d;
      beat_q      <= beat_d;
      last_beat_q <= last_beat_d;
      stop_q      <= stop_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      start_err_q <= start_err_d;
      pkt_cnt_q   <= pkt_cnt_d;
      len_v_q     <= len_v_d;
      spt_v_q     <= spt_v_d;
      dpt_v_q     <= dpt_v_d;
      err_v_q     <= err_v_d;
      dat_v_q     <= dat_v_d;
      dat_last_q  <= dat_last_d;
      dat_data_q  <= dat_data_d;
      dat_strb_q  <= dat_strb_d;
`ifdef PKTGEN_ERR_INJECT_EN
      err_every_q <= err_every_d;
      err_ctr_q   <= err_ctr_d;
`endif
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign start_err         = start_err_q;
  assign pkt_cnt           = pkt_cnt_q;
  assign m_axis.dat_tdata  = dat_data_q;
  assign m_axis.dat_tstrb  = dat_strb_q;
  assign m_axis.dat_tlast  = dat_last_q;
  assign m_axis.dat_tvalid = dat_v_q;
  assign m_axis.len_tdata  = len_q;
  assign m_axis.len_tvalid = len_v_q;
  assign m_axis.spt_tdata  = spt_q;
  assign m_axis.spt_tvalid = spt_v_q;
  assign m_axis.dpt_tdata  = dpt_q;
  assign m_axis.dpt_tvalid = dpt_v_q;
  assign m_axis.err_tdata  = err_q;
  assign m_axis.err_tvalid = err_v_q;

endmodule

// File: tb/tb_axis_pkt_src.sv
// Scoreboard bench for axis_pkt_src: expected beats are queued at issue, a monitor pops on handshake.
module tb_axis_pkt_src;
  logic        clk = 1'b0;
  logic        ARESET, start, stop;
  logic [15:0] pkt_len, num_pkts;
  logic [7:0]  spt, dpt;
`ifdef PKTGEN_ERR_INJECT_EN
  logic [7:0]  err_every;
`endif
  logic        busy, done, start_err;
  logic [31:0] pkt_cnt;

  always #5 clk = ~clk;

  axis_pkt_src_if bus ();

  axis_pkt_src dut (
    .ACLK      (clk),
    .ARESET    (ARESET),
    .start     (start),
    .stop      (stop),
    .pkt_len   (pkt_len),
    .num_pkts  (num_pkts),
    .spt       (spt),
    .dpt       (dpt),
`ifdef PKTGEN_ERR_INJECT_EN
    .err_every (err_every),
`endif
    .busy      (busy),
    .done      (done),
    .start_err (start_err),
    .pkt_cnt   (pkt_cnt),
    .m_axis    (bus)
  );

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  strb;
    logic         last;
    logic         fin;
  } dat_t;

  dat_t        exp_dat[$];
  dat_t        cap_dat[$];
  logic [15:0] exp_sb[4][$];
  logic [7:0]  cap_err[$];
  int          n_chk = 0;
  int          n_bad = 0;
  int          done_cnt = 0;
  int          sb_cnt[4];
  bit          rnd_ready = 1'b0;
  bit          chk_done_next = 1'b0;
  string       sb_nm[4] = '{"len", "spt", "dpt", "err"};

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_bad++;
    $display("FAIL %s: event not seen within bound", nm);
  endtask

  // Ready generator: all-ones or 50% random per channel, changed just after the edge.
  always @(posedge clk) begin
    #1;
    if (rnd_ready) begin
      bus.dat_tready = 1'($urandom_range(0, 1));
      bus.len_tready = 1'($urandom_range(0, 1));
      bus.spt_tready = 1'($urandom_range(0, 1));
      bus.dpt_tready = 1'($urandom_range(0, 1));
      bus.err_tready = 1'($urandom_range(0, 1));
    end else begin
      bus.dat_tready = 1'b1;
      bus.len_tready = 1'b1;
      bus.spt_tready = 1'b1;
      bus.dpt_tready = 1'b1;
      bus.err_tready = 1'b1;
    end
  end

  // Monitor: stall stability, handshake scoreboard, done timing.
  logic        pv_dat, pr_dat;
  dat_t        pd_dat;
  logic        pv[4], pr[4];
  logic [15:0] pd[4];
  always @(negedge clk) begin
    logic        v[4], r[4];
    logic [15:0] d[4];
    dat_t        cur, e;
    v[0] = bus.len_tvalid; r[0] = bus.len_tready; d[0] = bus.len_tdata;
    v[1] = bus.spt_tvalid; r[1] = bus.spt_tready; d[1] = {8'h00, bus.spt_tdata};
    v[2] = bus.dpt_tvalid; r[2] = bus.dpt_tready; d[2] = {8'h00, bus.dpt_tdata};
    v[3] = bus.err_tvalid; r[3] = bus.err_tready; d[3] = {8'h00, bus.err_tdata};
    cur = '{data: bus.dat_tdata, strb: bus.dat_tstrb, last: bus.dat_tlast, fin: 1'b0};
    if (ARESET) begin
      pv_dat = 1'b0;
      for (int c = 0; c < 4; c++) pv[c] = 1'b0;
      chk_done_next = 1'b0;
    end else begin
      if (chk_done_next) begin
        check("done_after_last_tlast", 256'(done), 256'(1));
        check("busy_after_last_tlast", 256'(busy), 256'(0));
        chk_done_next = 1'b0;
      end
      if (done) done_cnt++;
      if (pv_dat && !pr_dat) begin
        check("dat_valid_held", 256'(bus.dat_tvalid), 256'(1));
        check("dat_payload_stable", {cur.data ^ pd_dat.data}, 256'(0));
        check("dat_strb_last_stable", {cur.strb, cur.last}, {pd_dat.strb, pd_dat.last});
      end
      for (int c = 0; c < 4; c++) begin
        if (pv[c] && !pr[c]) begin
          check({sb_nm[c], "_valid_held"}, 256'(v[c]), 256'(1));
          check({sb_nm[c], "_data_stable"}, 256'(d[c]), 256'(pd[c]));
        end
        if (v[c] === 1'b1 && r[c] === 1'b1) begin
          sb_cnt[c]++;
          if (c == 3) cap_err.push_back(d[3][7:0]);
          if (exp_sb[c].size() == 0) fail_now({sb_nm[c], "_unexpected_beat"});
          else check({sb_nm[c], "_tdata"}, 256'(d[c]), 256'(exp_sb[c].pop_front()));
        end
        pv[c] = v[c]; pr[c] = r[c]; pd[c] = d[c];
      end
      if (bus.dat_tvalid === 1'b1 && bus.dat_tready === 1'b1) begin
        cap_dat.push_back(cur);
        if (exp_dat.size() == 0) begin
          fail_now("dat_unexpected_beat");
        end else begin
          e = exp_dat.pop_front();
          check("dat_tdata", cur.data, e.data);
          check("dat_tstrb", 256'(cur.strb), 256'(e.strb));
          check("dat_tlast", 256'(cur.last), 256'(e.last));
          if (e.fin) chk_done_next = 1'b1;
        end
      end
      pv_dat = bus.dat_tvalid; pr_dat = bus.dat_tready; pd_dat = cur;
    end
  end

  task automatic push_pkts(input int len, input int npk, input int sp, input int dp, input int ev,
                           input bit fin_last);
    int   nb;
    dat_t it;
    nb = (len + 31) / 32;
    for (int p = 0; p < npk; p++) begin
      exp_sb[0].push_back(16'(len));
      exp_sb[1].push_back(16'(sp));
      exp_sb[2].push_back(16'(dp));
      exp_sb[3].push_back((ev != 0 && ((p + 1) % ev) == 0) ? 16'd1 : 16'd0);
      for (int b = 0; b < nb; b++) begin
        it = '0;
        for (int i = 0; i < 8; i++) it.data[32*i +: 32] = {16'(p), 16'(8 * b + i)};
        it.last = (b == nb - 1);
        it.strb = (it.last && (len % 32) != 0) ? ((32'd1 << (len % 32)) - 32'd1) : 32'hFFFF_FFFF;
        it.fin  = fin_last && (p == npk - 1) && it.last;
        exp_dat.push_back(it);
      end
    end
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    start  = 1'b0;
    stop   = 1'b0;
    repeat (2) @(posedge clk);
    #1 ARESET = 1'b0;
    for (int c = 0; c < 4; c++) begin
      exp_sb[c].delete();
      sb_cnt[c] = 0;
    end
    exp_dat.delete();
    cap_dat.delete();
    cap_err.delete();
    done_cnt = 0;
  endtask

  task automatic kick(input int len, input int npk, input int sp, input int dp, input int ev);
    pkt_len  = 16'(len);
    num_pkts = 16'(npk);
    spt      = 8'(sp);
    dpt      = 8'(dp);
`ifdef PKTGEN_ERR_INJECT_EN
    err_every = 8'(ev);
`endif
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Full run: stop_at >= 0 means continuous mode, stopped during packet index stop_at.
  task automatic run(input int len, input int npk, input int sp, input int dp, input int ev,
                     input int stop_at, input int exp_cnt);
    int to;
    push_pkts(len, (npk == 0) ? stop_at + 1 : npk, sp, dp, ev, 1'b1);
    kick(len, npk, sp, dp, ev);
    check("busy_after_start", 256'(busy), 256'(1));
    check("len_valid_after_start", 256'(bus.len_tvalid), 256'(1));
    if (stop_at >= 0) begin
      to = 0;
      while (!(pkt_cnt == 32'(stop_at) && bus.dat_tvalid) && to < 5000) begin
        @(posedge clk);
        #1 to++;
      end
      if (to >= 5000) fail_now("reach_stop_packet");
      stop = 1'b1;
      @(posedge clk);
      #1 stop = 1'b0;
    end
    to = 0;
    while (busy && to < 20000) begin
      @(posedge clk);
      #1 to++;
    end
    if (to >= 20000) fail_now("run_completion");
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", 256'(done_cnt), 256'(1));
    check("pkt_cnt", 256'(pkt_cnt), 256'(exp_cnt));
    check("dat_expect_drained", 256'(exp_dat.size()), 256'(0));
  endtask

  initial begin
    int to;
    pkt_len  = '0;
    num_pkts = '0;
    spt      = '0;
    dpt      = '0;
`ifdef PKTGEN_ERR_INJECT_EN
    err_every = '0;
`endif
    do_reset();
    @(posedge clk);
    #1;
    check("rst_dat_valid", 256'(bus.dat_tvalid), 256'(0));
    check("rst_sb_valids", 256'({bus.len_tvalid, bus.spt_tvalid, bus.dpt_tvalid, bus.err_tvalid}),
          256'(0));
    check("rst_flags", 256'({busy, done, start_err, bus.dat_tlast}), 256'(0));
    check("rst_pkt_cnt", 256'(pkt_cnt), 256'(0));
    check("rst_dat_tdata", bus.dat_tdata, 256'(0));

    // Single 64-byte packet.
    run(64, 1, 8'h12, 8'h34, 0, -1, 1);
    check("t1_beats", 256'(cap_dat.size()), 256'(2));
    if (cap_dat.size() == 2) begin
      check("t1_strb_beat0", 256'(cap_dat[0].strb), 256'(32'hFFFF_FFFF));
      check("t1_strb_beat1", 256'(cap_dat[1].strb), 256'(32'hFFFF_FFFF));
      check("t1_lane0_beat1", 256'(cap_dat[1].data[31:0]), 256'(32'h0000_0008));
      check("t1_tlast_beat1", 256'(cap_dat[1].last), 256'(1));
    end

    // Three 33-byte packets: one-byte tail beat.
    do_reset();
    run(33, 3, 8'hA5, 8'h5A, 0, -1, 3);
    check("t2_beats", 256'(cap_dat.size()), 256'(6));
    if (cap_dat.size() == 6) begin
      check("t2_tail_strb", 256'(cap_dat[1].strb), 256'(32'h0000_0001));
      check("t2_pkt2_lane0", 256'(cap_dat[4].data[31:0]), 256'(32'h0002_0000));
    end

    // Ten 100-byte packets under random backpressure.
    do_reset();
    rnd_ready = 1'b1;
    run(100, 10, 8'h01, 8'h02, 0, -1, 10);
    rnd_ready = 1'b0;
    check("t3_beats", 256'(cap_dat.size()), 256'(40));
    if (cap_dat.size() == 40) check("t3_tail_strb", 256'(cap_dat[3].strb), 256'(32'h0000_000F));
    for (int c = 0; c < 4; c++) check({"t3_", sb_nm[c], "_beats"}, 256'(sb_cnt[c]), 256'(10));

    // Continuous mode, stop during packet 5.
    do_reset();
    run(100, 0, 8'h07, 8'h08, 0, 5, 6);

    // Zero-length start is rejected.
    do_reset();
    kick(0, 1, 0, 0, 0);
    check("start_err_pulse", 256'(start_err), 256'(1));
    check("start_err_busy", 256'(busy), 256'(0));
    check("start_err_no_hdr", 256'(bus.len_tvalid), 256'(0));
    @(posedge clk);
    #1;
    check("start_err_one_cycle", 256'(start_err), 256'(0));
    check("start_err_busy_later", 256'(busy), 256'(0));

    // Reset while streaming DATA.
    do_reset();
    push_pkts(64, 16, 8'h11, 8'h22, 0, 1'b0);
    kick(64, 0, 8'h11, 8'h22, 0);
    to = 0;
    while (!(pkt_cnt >= 32'd2 && bus.dat_tvalid) && to < 2000) begin
      @(posedge clk);
      #1 to++;
    end
    if (to >= 2000) fail_now("reach_data_for_reset");
    ARESET = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_valids", 256'({bus.dat_tvalid, bus.len_tvalid, bus.spt_tvalid, bus.dpt_tvalid,
                                  bus.err_tvalid}), 256'(0));
    check("mid_rst_pkt_cnt", 256'(pkt_cnt), 256'(0));
    check("mid_rst_busy", 256'(busy), 256'(0));
    do_reset();

`ifdef PKTGEN_ERR_INJECT_EN
    // Error tag on every third packet.
    do_reset();
    run(64, 6, 8'h03, 8'h04, 3, -1, 6);
    check("err_caps", 256'(cap_err.size()), 256'(6));
    if (cap_err.size() == 6) begin
      check("err_pkt1", 256'(cap_err[1]), 256'(0));
      check("err_pkt2", 256'(cap_err[2]), 256'(1));
      check("err_pkt5", 256'(cap_err[5]), 256'(1));
    end
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
